// File: rtl/simple_bank_queue_mgr_pkg.sv
// Shared sizing and constants for the bank queue manager.
// Contents: count/teller/wait-time widths, service time per customer,
//           saturation limit of the people counter and the no-teller wait value.
package sbqm_pkg;

    localparam int CNT_W        = 3;
    localparam int TELLER_W     = 2;
    localparam int WTIME_W      = 5;
    localparam int SERVICE_TIME = 3;

    localparam logic [CNT_W-1:0]   CNT_MAX         = 3'd7;
    localparam logic [WTIME_W-1:0] WTIME_NO_TELLER = 5'd31;

    typedef logic [CNT_W-1:0]    pcount_t;
    typedef logic [TELLER_W-1:0] tcount_t;
    typedef logic [WTIME_W-1:0]  wtime_t;

endpackage

// File: rtl/simple_bank_queue_mgr_if.sv
// Bundle of photocell/teller inputs and queue status outputs.
// master: photocell front-end / display side (drives backPC, frontPC, Tcount).
// slave : queue manager (drives Pcount, Wtime, full, empty).
interface simple_bank_queue_mgr_if;
    import sbqm_pkg::*;

    logic    backPC;
    logic    frontPC;
    tcount_t Tcount;
    pcount_t Pcount;
    wtime_t  Wtime;
    logic    full;
    logic    empty;

    modport master (
        output backPC, frontPC, Tcount,
        input  Pcount, Wtime, full, empty
    );

    modport slave (
        input  backPC, frontPC, Tcount,
        output Pcount, Wtime, full, empty
    );

endinterface

// File: rtl/simple_bank_queue_mgr_wtime_calc.sv
// Estimated waiting time from people count and active tellers.
// Latency: purely combinational, no state.
// Ports: pcount (in), tcount (in), wtime (out).
module sbqm_wtime_calc
    import sbqm_pkg::*;
(
    input  pcount_t pcount,
    input  tcount_t tcount,
    output wtime_t  wtime
);

    // 6 bits covers the largest numerator, 3*(7+3-1) = 27, with margin.
    logic [5:0] num;
    logic [5:0] den;
    logic [5:0] quo;

    always_comb begin
        num = 6'(SERVICE_TIME) * (6'(pcount) + 6'(tcount) - 6'd1);
        // Divisor forced non-zero so the divider never sees 0; that case is muxed out below.
        den = (tcount == '0) ? 6'd1 : 6'(tcount);
        quo = num / den;

        wtime = '0;
        if (pcount == '0) begin
            wtime = '0;
        end else if (tcount == '0) begin
            wtime = WTIME_NO_TELLER;
        end else begin
            wtime = WTIME_W'(quo);
        end
    end

endmodule

// File: rtl/simple_bank_queue_mgr.sv
// Bank queue manager: photocell edge detect, saturating people counter, full/empty, wait time.
// Latency: 1 cycle from photocell falling edge to Pcount (3 cycles with SBQM_SYNC_IN_EN defined,
//          which adds a 2-flop synchronizer on each photocell). Flags/Wtime are combinational.
// Ports: clk, rst (async active-high), bus (slave modport: backPC, frontPC, Tcount in; Pcount, Wtime, full, empty out).
module simple_bank_queue_mgr
    import sbqm_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    simple_bank_queue_mgr_if.slave  bus
);

    logic back_in;
    logic front_in;

`ifdef SBQM_SYNC_IN_EN
    logic [1:0] back_sync_q,  back_sync_d;
    logic [1:0] front_sync_q, front_sync_d;

    always_comb begin
        back_sync_d  = {back_sync_q[0],  bus.backPC};
        front_sync_d = {front_sync_q[0], bus.frontPC};
    end

    // Reset to idle-high so release of reset never looks like a falling edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            back_sync_q  <= 2'b11;
            front_sync_q <= 2'b11;
        end else begin
            back_sync_q  <= back_sync_d;
            front_sync_q <= front_sync_d;
        end
    end

    assign back_in  = back_sync_q[1];
    assign front_in = front_sync_q[1];
`else
    assign back_in  = bus.backPC;
    assign front_in = bus.frontPC;
`endif

    logic    prev_back_q,  prev_back_d;
    logic    prev_front_q, prev_front_d;
    pcount_t pcount_q,     pcount_d;
    logic    up;
    logic    down;

    always_comb begin
        prev_back_d  = back_in;
        prev_front_d = front_in;

        // A photocell pulse counts only on its high-to-low transition, so a long pulse counts once.
        up   = prev_back_q  & ~back_in;
        down = prev_front_q & ~front_in;

        pcount_d = pcount_q;
        case ({up, down})
            2'b10: if (pcount_q != CNT_MAX) pcount_d = pcount_q + 1'b1;
            2'b01: if (pcount_q != '0)      pcount_d = pcount_q - 1'b1;
            default: pcount_d = pcount_q;   // entry and exit together cancel out
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_back_q  <= 1'b1;
            prev_front_q <= 1'b1;
            pcount_q     <= '0;
        end else begin
            prev_back_q  <= prev_back_d;
            prev_front_q <= prev_front_d;
            pcount_q     <= pcount_d;
        end
    end

    wtime_t wtime;

    sbqm_wtime_calc u_wtime_calc (
        .pcount (pcount_q),
        .tcount (bus.Tcount),
        .wtime  (wtime)
    );

    assign bus.Pcount = pcount_q;
    assign bus.Wtime  = wtime;
    assign bus.full   = (pcount_q == CNT_MAX);
    assign bus.empty  = (pcount_q == '0);

endmodule

// File: tb/tb_simple_bank_queue_mgr.sv
// Bench for simple_bank_queue_mgr: directed scenarios plus random photocell traffic,
// compared each cycle against a queue-occupancy model; a few literal expectations pin the model.
module tb_simple_bank_queue_mgr;

    logic clk = 1'b0;
    logic rst = 1'b1;

    simple_bank_queue_mgr_if bus ();

    simple_bank_queue_mgr dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;

    // Model state: occupancy and last seen photocell level (after any input delay).
    int m_cnt    = 0;
    bit m_prev_b = 1'b1;
    bit m_prev_f = 1'b1;
`ifdef SBQM_SYNC_IN_EN
    bit m_db [2] = '{1'b1, 1'b1};
    bit m_df [2] = '{1'b1, 1'b1};
`endif

    function automatic int model_wtime(input int p, input int t);
        if (p == 0) return 0;
        if (t == 0) return 31;
        return (3 * (p + t - 1)) / t;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt    = 0;
        m_prev_b = 1'b1;
        m_prev_f = 1'b1;
`ifdef SBQM_SYNC_IN_EN
        m_db = '{1'b1, 1'b1};
        m_df = '{1'b1, 1'b1};
`endif
    endtask

    always @(posedge rst) model_reset();

    // Model update on each clock edge, then compare every output 1 time unit later.
    always @(posedge clk) begin
        bit b, f, en, ex;
        if (rst) begin
            model_reset();
        end else begin
`ifdef SBQM_SYNC_IN_EN
            b = m_db[1];
            f = m_df[1];
            m_db[1] = m_db[0]; m_db[0] = bus.backPC;
            m_df[1] = m_df[0]; m_df[0] = bus.frontPC;
`else
            b = bus.backPC;
            f = bus.frontPC;
`endif
            en = m_prev_b && !b;
            ex = m_prev_f && !f;
            m_prev_b = b;
            m_prev_f = f;
            if (en && !ex && m_cnt < 7) m_cnt++;
            else if (ex && !en && m_cnt > 0) m_cnt--;
        end
        #1;
        check("Pcount", int'(bus.Pcount), m_cnt);
        check("Wtime",  int'(bus.Wtime),  model_wtime(m_cnt, int'(bus.Tcount)));
        check("full",   int'(bus.full),   (m_cnt == 7) ? 1 : 0);
        check("empty",  int'(bus.empty),  (m_cnt == 0) ? 1 : 0);
    end

    task automatic step(input logic b, input logic f, input logic [1:0] t);
        @(negedge clk);
        bus.backPC  = b;
        bus.frontPC = f;
        bus.Tcount  = t;
        @(posedge clk);
        #2;
    endtask

    task automatic pulse(input logic b, input logic f, input logic [1:0] t);
        step(b, f, t);
        step(1'b1, 1'b1, t);
        step(1'b1, 1'b1, t);
    endtask

    initial begin
        bus.backPC  = 1'b1;
        bus.frontPC = 1'b1;
        bus.Tcount  = 2'd1;

        // Reset state
        repeat (3) @(posedge clk);
        #2;
        check("rst_Pcount", int'(bus.Pcount), 0);
        check("rst_empty",  int'(bus.empty),  1);
        check("rst_full",   int'(bus.full),   0);
        check("rst_Wtime",  int'(bus.Wtime),  0);
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, 1'b1, 2'd1);

        // Fill with one teller: counts 1..7 then saturates, Wtime 3*P
        for (int i = 1; i <= 8; i++) begin
            pulse(1'b0, 1'b1, 2'd1);
            check("fill_Pcount", int'(bus.Pcount), (i > 7) ? 7 : i);
            check("fill_Wtime",  int'(bus.Wtime),  3 * ((i > 7) ? 7 : i));
        end
        check("fill_full", int'(bus.full), 1);

        // Drain: 6..0 then stays 0
        for (int i = 1; i <= 8; i++) begin
            pulse(1'b1, 1'b0, 2'd1);
            check("drain_Pcount", int'(bus.Pcount), (7 - i < 0) ? 0 : 7 - i);
        end
        check("drain_empty", int'(bus.empty), 1);
        check("drain_Wtime", int'(bus.Wtime), 0);

        // Simultaneous entry/exit at 0 and at 3
        pulse(1'b0, 1'b0, 2'd1);
        check("both_at0", int'(bus.Pcount), 0);
        repeat (3) pulse(1'b0, 1'b1, 2'd1);
        pulse(1'b0, 1'b0, 2'd1);
        check("both_at3", int'(bus.Pcount), 3);

        // Wtime at Pcount 5 for several teller counts
        repeat (2) pulse(1'b0, 1'b1, 2'd1);
        check("p5", int'(bus.Pcount), 5);
        step(1'b1, 1'b1, 2'd3);
        check("w_p5_t3", int'(bus.Wtime), 7);
        step(1'b1, 1'b1, 2'd2);
        check("w_p5_t2", int'(bus.Wtime), 9);
        step(1'b1, 1'b1, 2'd0);
        check("w_p5_t0", int'(bus.Wtime), 31);

        // Long low pulse counts once
        repeat (4) step(1'b0, 1'b1, 2'd1);
        repeat (3) step(1'b1, 1'b1, 2'd1);
        check("long_pulse", int'(bus.Pcount), 6);

        // Asynchronous reset in the middle of a pulse; pulse ends before release
        step(1'b0, 1'b1, 2'd1);
        rst = 1'b1;
        #1;
        check("async_rst", int'(bus.Pcount), 0);
        step(1'b0, 1'b1, 2'd1);
        step(1'b1, 1'b1, 2'd1);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) step(1'b1, 1'b1, 2'd1);
        check("post_rst", int'(bus.Pcount), 0);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 2) != 0), ($urandom_range(0, 2) != 0),
                 2'($urandom_range(0, 3)));
        end

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
